serial_magnitude_comparator: RTL
================================

// Module: serial_magnitude_comparator
// PURPOSE
//   Multi-cycle magnitude comparator for two WIDTH-bit operands, signed or unsigned.
//   Scans MSB-first, STEP bits per cycle, and stops at the first differing chunk.
//   Returns one-hot eq/lt/gt with a start/done handshake.
//   Used by the ALU's compare unit and branch-condition logic.
// PARAMETERS
//   WIDTH  8  operand width in bits; must be >= 1
//   STEP   1  bits compared per cycle; WIDTH % STEP != 0 is an elaboration error
// PORTS
//   clk          in   1      single clock, all state updates on rising edge
//   reset        in   1      synchronous, active-high
//   start        in   1      request a compare; accepted only when busy==0
//   signed_mode  in   1      1 = two's-complement compare, 0 = unsigned; sampled with start
//   a            in   WIDTH  operand A, sampled with start
//   b            in   WIDTH  operand B, sampled with start
//   busy         out  1      high from the cycle after acceptance until done has been shown
//   done         out  1      one-cycle pulse; eq/lt/gt are valid from this cycle
//   eq           out  1      a == b
//   lt           out  1      a <  b under the sampled mode
//   gt           out  1      a >  b under the sampled mode
// BEHAVIOUR
//   Clock and reset: one clock; reset is synchronous and active-high.
//   Reset values: state=IDLE, busy=0, done=0, eq=lt=gt=0, internal regs=0.
//   Reset has priority over every other input.
//   Reset during SCAN or DONE aborts the compare: no done pulse, results stay 0.
//   Chunks: N = WIDTH/STEP; chunk i = bits [i*STEP+STEP-1 : i*STEP].
//   FSM, 3 states:
//   - IDLE: busy=0. When start=1:
//     - capture a and b into ra and rb; if signed_mode, invert bit WIDTH-1 of both
//       (offset-binary, so an unsigned compare gives the signed result);
//     - idx <= N-1; eq=lt=gt <= 0; go to SCAN.
//   - SCAN: busy=1. Compare ra chunk idx with rb chunk idx, unsigned.
//     - Chunks differ: lt <= (ra chunk < rb chunk), gt <= !lt, go to DONE.
//     - Chunks equal and idx==0: eq <= 1, go to DONE.
//     - Otherwise: idx <= idx-1, stay in SCAN.
//   - DONE: busy=1, done=1 for exactly this cycle; go to IDLE next cycle.
//   Latency: start is high in cycle 0.
//     k = number of chunks examined (1..N).
//     done is high in cycle k+1. Best case 2 cycles, worst case N+1.
//   Results: eq/lt/gt are one-hot from the done cycle.
//     They are held until the next accepted start, which clears them to 000.
//   Inputs: start is ignored while busy=1, including the DONE cycle; no queuing.
//     a, b and signed_mode may change freely after acceptance.
//   Back-to-back: start in the first IDLE cycle after DONE is accepted normally.
//   Width rules: idx is $clog2(N) bits, min 1. No arithmetic beyond chunk compare.
//   Corner cases: N==1 completes in 2 cycles; WIDTH==1 with signed_mode gives 1 (= -1) < 0.
// TESTING
//   1. WIDTH=8, STEP=1, unsigned, a=0x06, b=0x07
//      -> lt=1, eq=gt=0; done in cycle 9 (k=8).
//   2. Unsigned a=0x80, b=0x01 -> gt=1, done in cycle 2.
//      Same operands, signed_mode=1 -> lt=1 (-128 < 1), done in cycle 2.
//   3. a=b=0xA5, both modes -> eq=1, done in cycle 9.
//      Results held while idle; cleared to 000 at the next accepted start.
//   4. WIDTH=8, STEP=4, a=0x37, b=0x39 -> lt=1, done in cycle 3 (k=2).
//      a=0xF0, b=0x0F signed -> lt=1, done in cycle 2.
//   5. Start at cycle 0, reset=1 in cycle 3 -> busy=0, done never pulses, eq=lt=gt=0.
//      A start two cycles later completes correctly.
//   6. Start re-asserted with new operands in every SCAN and DONE cycle -> ignored,
//      result matches the first operands. Start in the first IDLE cycle is accepted.

Source files
------------

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, STEP bits per cycle, signed or unsigned.
// Stops at the first differing chunk and reports one-hot eq/lt/gt with a done pulse.
module serial_magnitude_comparator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int unsigned N    = WIDTH / STEP;
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 1 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_params
    $error("serial_magnitude_comparator: WIDTH must be >= 1 and a multiple of STEP");
  end

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [WIDTH-1:0]  ra;
  logic [WIDTH-1:0]  rb;
  logic [IDXW-1:0]   idx;
  logic [WIDTH-1:0]  ra_sh;
  logic [WIDTH-1:0]  rb_sh;
  logic [STEP-1:0]   ra_chunk;
  logic [STEP-1:0]   rb_chunk;
  logic              chunk_diff;
  logic              chunk_lt;
  logic              last_chunk;

  always_comb begin
    ra_sh      = ra >> (STEP * 32'(idx));
    rb_sh      = rb >> (STEP * 32'(idx));
    ra_chunk   = ra_sh[STEP-1:0];
    rb_chunk   = rb_sh[STEP-1:0];
    chunk_diff = (ra_chunk != rb_chunk);
    chunk_lt   = (ra_chunk < rb_chunk);
    last_chunk = (idx == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (chunk_diff || last_chunk) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Signed operands are stored offset-binary (MSB flipped) so the scan is always unsigned.
  always_ff @(posedge clk) begin
    if (reset) begin
      ra  <= '0;
      rb  <= '0;
      idx <= '0;
      eq  <= 1'b0;
      lt  <= 1'b0;
      gt  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra           <= a;
            rb           <= b;
            ra[WIDTH-1]  <= a[WIDTH-1] ^ signed_mode;
            rb[WIDTH-1]  <= b[WIDTH-1] ^ signed_mode;
            idx          <= IDXW'(N - 1);
            eq           <= 1'b0;
            lt           <= 1'b0;
            gt           <= 1'b0;
          end
        end
        SCAN: begin
          if (chunk_diff) begin
            lt <= chunk_lt;
            gt <= !chunk_lt;
          end else if (last_chunk) begin
            eq <= 1'b1;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
